// File: rtl/forwarding_pkg.sv
// Shared forwarding types: the pipeline-stage forwarding entry, the stall-cause
// FSM state and the number of forwarding sources.
package forwarding;

   localparam int XLEN        = 32;
   localparam int REG_ADDR_W  = 5;
   localparam int NUM_FWD_SRC = 3;

   // One in-flight producer: data_valid = 0 means the value is not ready yet (e.g. a load).
   typedef struct packed {
      logic                  data_valid;
      logic [XLEN-1:0]       data;
      logic [REG_ADDR_W-1:0] addr;
   } t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MC_STALL   = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/forwarding_ctrl_mux.sv
// Per-operand forwarding selection and hazard detection; sources are ordered
// highest priority first (EX, MEM, WB) and the register file is the fallback.
module forwarding_mux
   import forwarding::*;
(
   input  t                      src [NUM_FWD_SRC],
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic                  rs_used,
   input  logic [XLEN-1:0]       rs_rf,
   input  logic [31:0]           pending,
   input  logic                  mc_done,
   input  logic [REG_ADDR_W-1:0] mc_done_rd,
   output logic [XLEN-1:0]       rs_data,
   output logic                  load_hazard,
   output logic                  mc_hazard
);

   logic hit;
   logic sel_ready;

   // Only the first matching source counts; x0 never matches anything.
   always_comb begin
      rs_data   = rs_rf;
      sel_ready = 1'b1;
      hit       = 1'b0;
      if (rs_addr == '0) begin
         rs_data = '0;
      end else begin
         for (int k = 0; k < NUM_FWD_SRC; k++) begin
            if (!hit && src[k].addr == rs_addr) begin
               hit       = 1'b1;
               rs_data   = src[k].data;
               sel_ready = src[k].data_valid;
            end
         end
      end
   end

   assign load_hazard = rs_used && !sel_ready;

   // A completion landing this same cycle releases the operand without waiting a cycle.
   assign mc_hazard = rs_used && pending[rs_addr] &&
                      !(mc_done && mc_done_rd == rs_addr);

endmodule

// File: rtl/forwarding_ctrl.sv
// Forwarding / interlock controller: operand bypass, load and multicycle scoreboard
// stalls, stall-cause FSM. Define FORWARDING_CTRL_STATS_EN to add the stall_cycles counter.
module forwarding_ctrl
   import forwarding::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  t                      ex_fwd,
   input  t                      mem_fwd,
   input  t                      wb_fwd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic [XLEN-1:0]       rs1_rf,
   input  logic [XLEN-1:0]       rs2_rf,
   input  logic                  mc_issue,
   input  logic [REG_ADDR_W-1:0] mc_rd,
   input  logic                  mc_done,
   input  logic [REG_ADDR_W-1:0] mc_done_rd,
   input  logic                  stats_clr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   pending,
   output logic [1:0]            state
`ifdef FORWARDING_CTRL_STATS_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   t                  srcs [NUM_FWD_SRC];
   logic [31:0]       pending_ext;
   logic [NUM_REGS-1:0] pending_next;
   logic              load_hz1, load_hz2, mc_hz1, mc_hz2;
   logic              load_any, mc_any;
   ctrl_state_t       state_q, state_next;

   assign srcs[0]     = ex_fwd;
   assign srcs[1]     = mem_fwd;
   assign srcs[2]     = wb_fwd;
   assign pending_ext = 32'(pending);

   forwarding_mux u_mux_rs1 (
      .src         (srcs),
      .rs_addr     (rs1_addr),
      .rs_used     (rs1_used),
      .rs_rf       (rs1_rf),
      .pending     (pending_ext),
      .mc_done     (mc_done),
      .mc_done_rd  (mc_done_rd),
      .rs_data     (rs1_data),
      .load_hazard (load_hz1),
      .mc_hazard   (mc_hz1)
   );

   forwarding_mux u_mux_rs2 (
      .src         (srcs),
      .rs_addr     (rs2_addr),
      .rs_used     (rs2_used),
      .rs_rf       (rs2_rf),
      .pending     (pending_ext),
      .mc_done     (mc_done),
      .mc_done_rd  (mc_done_rd),
      .rs_data     (rs2_data),
      .load_hazard (load_hz2),
      .mc_hazard   (mc_hz2)
   );

   assign load_any = load_hz1 || load_hz2;
   assign mc_any   = mc_hz1 || mc_hz2;
   assign stall    = load_any || mc_any;

   // Clear first so a same-cycle issue to the same register wins; a stalled issue is dropped.
   always_comb begin
      pending_next = pending;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (mc_done && mc_done_rd == REG_ADDR_W'(i))
            pending_next[i] = 1'b0;
         if (mc_issue && !stall && mc_rd == REG_ADDR_W'(i))
            pending_next[i] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_comb begin
      state_next = RUN;
      if (load_any)
         state_next = LOAD_STALL;
      else if (mc_any)
         state_next = MC_STALL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         state_q <= RUN;
      end else begin
         pending <= pending_next;
         state_q <= state_next;
      end
   end

   assign state = state_q;

`ifdef FORWARDING_CTRL_STATS_EN
   // Clear beats increment; the count sticks at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stats_clr)
         stall_cycles <= '0;
      else if (stall && stall_cycles != 32'hFFFF_FFFF)
         stall_cycles <= stall_cycles + 32'd1;
   end
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
`endif

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Self-checking bench for forwarding_ctrl: directed vector table, hand-written
// scoreboard/reset/stats sequences, and randomized cycles against a reference model.
module tb_forwarding_ctrl;
   import forwarding::*;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_MC   = 2'd2;

   logic        clk;
   logic        rst_n;
   t            ex_fwd, mem_fwd, wb_fwd;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_used, rs2_used;
   logic [31:0] rs1_rf, rs2_rf;
   logic        mc_issue;
   logic [4:0]  mc_rd;
   logic        mc_done;
   logic [4:0]  mc_done_rd;
   logic        stats_clr;
   logic [31:0] rs1_data, rs2_data;
   logic        stall;
   logic [31:0] pending;
   logic [1:0]  state;
`ifdef FORWARDING_CTRL_STATS_EN
   logic [31:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] pend_model;
   logic [31:0] cnt_model;

   typedef struct {
      t            ex;
      t            mem;
      t            wb;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        u1;
      logic        u2;
      logic [31:0] rf1;
      logic [31:0] rf2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        estall;
      logic [1:0]  estate;
   } vec_t;

   vec_t vecs [8];

   forwarding_ctrl #(.NUM_REGS(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_fwd       (ex_fwd),
      .mem_fwd      (mem_fwd),
      .wb_fwd       (wb_fwd),
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_used     (rs1_used),
      .rs2_used     (rs2_used),
      .rs1_rf       (rs1_rf),
      .rs2_rf       (rs2_rf),
      .mc_issue     (mc_issue),
      .mc_rd        (mc_rd),
      .mc_done      (mc_done),
      .mc_done_rd   (mc_done_rd),
      .stats_clr    (stats_clr),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .stall        (stall),
      .pending      (pending),
      .state        (state)
`ifdef FORWARDING_CTRL_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      ex_fwd     = '0;
      mem_fwd    = '0;
      wb_fwd     = '0;
      rs1_addr   = 5'd0;
      rs2_addr   = 5'd0;
      rs1_used   = 1'b0;
      rs2_used   = 1'b0;
      rs1_rf     = 32'h0;
      rs2_rf     = 32'h0;
      mc_issue   = 1'b0;
      mc_rd      = 5'd0;
      mc_done    = 1'b0;
      mc_done_rd = 5'd0;
      stats_clr  = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      ex_fwd   = v.ex;
      mem_fwd  = v.mem;
      wb_fwd   = v.wb;
      rs1_addr = v.a1;
      rs2_addr = v.a2;
      rs1_used = v.u1;
      rs2_used = v.u2;
      rs1_rf   = v.rf1;
      rs2_rf   = v.rf2;
   endtask

   // Reference: walk producers youngest-first, first address match supplies the value.
   task automatic model_operand(input logic [4:0] a, input logic [31:0] rf,
                                output logic [31:0] d, output bit waiting);
      t   stages [3];
      bit found;
      stages[0] = ex_fwd;
      stages[1] = mem_fwd;
      stages[2] = wb_fwd;
      found     = 1'b0;
      d         = rf;
      waiting   = 1'b0;
      if (a == 5'd0) begin
         d = 32'h0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (!found && stages[k].addr == a) begin
               found   = 1'b1;
               d       = stages[k].data;
               waiting = !stages[k].data_valid;
            end
         end
      end
   endtask

   function automatic bit reg_busy(input logic [4:0] a);
      return pend_model[a] && !(mc_done && mc_done_rd == a);
   endfunction

   task automatic random_cycle();
      logic [31:0] d1, d2, nxt;
      bit          w1, w2, ld, mc;
      logic [1:0]  est;
      @(negedge clk);
      ex_fwd     = '{data_valid: ($urandom_range(0, 3) != 0), data: $urandom, addr: 5'($urandom_range(0, 7))};
      mem_fwd    = '{data_valid: ($urandom_range(0, 3) != 0), data: $urandom, addr: 5'($urandom_range(0, 7))};
      wb_fwd     = '{data_valid: ($urandom_range(0, 3) != 0), data: $urandom, addr: 5'($urandom_range(0, 7))};
      rs1_addr   = 5'($urandom_range(0, 7));
      rs2_addr   = 5'($urandom_range(0, 7));
      rs1_used   = 1'($urandom_range(0, 1));
      rs2_used   = 1'($urandom_range(0, 1));
      rs1_rf     = $urandom;
      rs2_rf     = $urandom;
      mc_issue   = ($urandom_range(0, 2) == 0);
      mc_rd      = 5'($urandom_range(0, 7));
      mc_done    = ($urandom_range(0, 3) == 0);
      mc_done_rd = 5'($urandom_range(0, 7));
      stats_clr  = ($urandom_range(0, 15) == 0);

      model_operand(rs1_addr, rs1_rf, d1, w1);
      model_operand(rs2_addr, rs2_rf, d2, w2);
      ld = (rs1_used && w1) || (rs2_used && w2);
      mc = (rs1_used && reg_busy(rs1_addr)) || (rs2_used && reg_busy(rs2_addr));

      #1;
      check_output("rnd_rs1_data", rs1_data, d1);
      check_output("rnd_rs2_data", rs2_data, d2);
      check_output("rnd_stall", 32'(stall), 32'(ld || mc));

      nxt = pend_model;
      if (mc_done) nxt[mc_done_rd] = 1'b0;
      if (mc_issue && !(ld || mc) && mc_rd != 5'd0) nxt[mc_rd] = 1'b1;
      est = ld ? ST_LOAD : (mc ? ST_MC : ST_RUN);
      if (stats_clr) cnt_model = 32'h0;
      else if ((ld || mc) && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;

      @(posedge clk);
      #1;
      pend_model = nxt;
      check_output("rnd_pending", pending, pend_model);
      check_output("rnd_state", 32'(state), 32'(est));
`ifdef FORWARDING_CTRL_STATS_EN
      check_output("rnd_stall_cycles", stall_cycles, cnt_model);
`endif
   endtask

   initial begin
      set_idle();
      rst_n = 1'b0;

      vecs[0] = '{'{1'b1, 32'hAAAA0001, 5'd5}, '{1'b1, 32'hBBBB0002, 5'd5}, '{1'b0, 32'h0, 5'd0},
                  5'd5, 5'd6, 1'b1, 1'b1, 32'h11111111, 32'h22222222,
                  32'hAAAA0001, 32'h22222222, 1'b0, ST_RUN};
      vecs[1] = '{'{1'b0, 32'h0, 5'd7}, '{1'b1, 32'h00000012, 5'd7}, '{1'b0, 32'h0, 5'd0},
                  5'd1, 5'd7, 1'b0, 1'b1, 32'h00000001, 32'h00000003,
                  32'h00000001, 32'h0, 1'b1, ST_LOAD};
      vecs[2] = '{'{1'b0, 32'h0, 5'd7}, '{1'b1, 32'h00000012, 5'd7}, '{1'b0, 32'h0, 5'd0},
                  5'd1, 5'd7, 1'b0, 1'b0, 32'h00000001, 32'h00000003,
                  32'h00000001, 32'h0, 1'b0, ST_RUN};
      vecs[3] = '{'{1'b0, 32'h0, 5'd0}, '{1'b0, 32'h0, 5'd0}, '{1'b1, 32'hFFFFFFFF, 5'd0},
                  5'd0, 5'd0, 1'b1, 1'b1, 32'h00000055, 32'h00000066,
                  32'h0, 32'h0, 1'b0, ST_RUN};
      vecs[4] = '{'{1'b1, 32'h0000E003, 5'd3}, '{1'b1, 32'h0BAD0002, 5'd4}, '{1'b1, 32'h00000CCC, 5'd4},
                  5'd4, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2,
                  32'h0BAD0002, 32'h0000E003, 1'b0, ST_RUN};
      vecs[5] = '{'{1'b1, 32'h1, 5'd1}, '{1'b1, 32'h2, 5'd2}, '{1'b1, 32'h00000077, 5'd8},
                  5'd8, 5'd9, 1'b1, 1'b1, 32'h3, 32'h99990009,
                  32'h00000077, 32'h99990009, 1'b0, ST_RUN};
      vecs[6] = '{'{1'b1, 32'h00000099, 5'd10}, '{1'b0, 32'h5, 5'd10}, '{1'b0, 32'h6, 5'd10},
                  5'd10, 5'd0, 1'b1, 1'b0, 32'h7, 32'h8,
                  32'h00000099, 32'h0, 1'b0, ST_RUN};
      vecs[7] = '{'{1'b1, 32'h1, 5'd2}, '{1'b0, 32'h5, 5'd11}, '{1'b1, 32'h6, 5'd11},
                  5'd11, 5'd2, 1'b1, 1'b1, 32'h7, 32'h8,
                  32'h5, 32'h1, 1'b1, ST_LOAD};

      // Reset values
      #12;
      check_output("reset_pending", pending, 32'h0);
      check_output("reset_state", 32'(state), 32'(ST_RUN));
`ifdef FORWARDING_CTRL_STATS_EN
      check_output("reset_stall_cycles", stall_cycles, 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with an empty scoreboard
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("vec%0d_rs1_data", i), rs1_data, vecs[i].e1);
         check_output($sformatf("vec%0d_rs2_data", i), rs2_data, vecs[i].e2);
         check_output($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].estall));
         @(posedge clk);
         #1;
         check_output($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].estate));
      end

      // Scoreboard: issue, dependent stall, same-cycle completion
      @(negedge clk);
      set_idle();
      mc_issue = 1'b1;
      mc_rd    = 5'd9;
      #1 check_output("sb_issue_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1 check_output("sb_issue_pending", pending, 32'h200);
      @(negedge clk);
      mc_issue = 1'b0;
      rs1_addr = 5'd9;
      rs1_used = 1'b1;
      rs1_rf   = 32'h12345678;
      #1 check_output("sb_dep_stall", 32'(stall), 32'h1);
      @(posedge clk);
      #1 check_output("sb_dep_state", 32'(state), 32'(ST_MC));
      check_output("sb_dep_pending", pending, 32'h200);
      @(negedge clk);
      mc_done    = 1'b1;
      mc_done_rd = 5'd9;
      #1 check_output("sb_done_stall", 32'(stall), 32'h0);
      check_output("sb_done_rs1_data", rs1_data, 32'h12345678);
      @(posedge clk);
      #1 check_output("sb_done_pending", pending, 32'h0);
      check_output("sb_done_state", 32'(state), 32'(ST_RUN));

      // Issue while stalled is dropped
      @(negedge clk);
      set_idle();
      mc_issue = 1'b1;
      mc_rd    = 5'd9;
      @(posedge clk);
      @(negedge clk);
      mc_rd    = 5'd12;
      rs1_addr = 5'd9;
      rs1_used = 1'b1;
      @(posedge clk);
      #1 check_output("sb_issue_dropped", pending, 32'h200);
      @(negedge clk);
      set_idle();
      mc_done    = 1'b1;
      mc_done_rd = 5'd9;
      @(posedge clk);
      #1 check_output("sb_cleared", pending, 32'h0);

      // Set beats clear on the same register; x0 never becomes pending
      @(negedge clk);
      set_idle();
      mc_issue   = 1'b1;
      mc_rd      = 5'd3;
      mc_done    = 1'b1;
      mc_done_rd = 5'd3;
      @(posedge clk);
      #1 check_output("sb_set_wins", pending, 32'h8);
      @(negedge clk);
      set_idle();
      mc_issue = 1'b1;
      mc_rd    = 5'd0;
      @(posedge clk);
      #1 check_output("sb_x0_never_pending", pending, 32'h8);

      // Async reset mid-stall
      @(negedge clk);
      set_idle();
      rs1_addr = 5'd3;
      rs1_used = 1'b1;
      @(posedge clk);
      #1 check_output("rst_pre_state", 32'(state), 32'(ST_MC));
      #2 rst_n = 1'b0;
      #1 check_output("rst_async_pending", pending, 32'h0);
      check_output("rst_async_state", 32'(state), 32'(ST_RUN));
      @(negedge clk);
      set_idle();
      rst_n      = 1'b1;
      mc_done    = 1'b1;
      mc_done_rd = 5'd5;
      @(posedge clk);
      #1 check_output("rst_stray_done_pending", pending, 32'h0);
      check_output("rst_stray_done_state", 32'(state), 32'(ST_RUN));

`ifdef FORWARDING_CTRL_STATS_EN
      // Stall counter: counting, clear priority, saturation
      @(negedge clk);
      set_idle();
      ex_fwd   = '{data_valid: 1'b0, data: 32'h0, addr: 5'd7};
      rs1_addr = 5'd7;
      rs1_used = 1'b1;
      repeat (4) @(posedge clk);
      #1 check_output("stats_four", stall_cycles, 32'd4);
      @(negedge clk);
      stats_clr = 1'b1;
      @(posedge clk);
      #1 check_output("stats_clr_wins", stall_cycles, 32'd0);
      @(negedge clk);
      stats_clr = 1'b0;
      force dut.stall_cycles = 32'hFFFF_FFFE;
      #1 release dut.stall_cycles;
      @(posedge clk);
      #1 check_output("stats_reach_max", stall_cycles, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      #1 check_output("stats_saturate", stall_cycles, 32'hFFFF_FFFF);
`endif

      // Randomized cycles against the reference model, from a clean reset
      @(negedge clk);
      set_idle();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      pend_model = 32'h0;
      cnt_model  = 32'h0;
      for (int n = 0; n < 300; n++)
         random_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/forwarding_ctrl.md
FORWARDING_CTRL -- requirements
Module: forwarding_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning architectural register count (index 0 hardwired to zero).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- ex_fwd  in  forwarding::t  entry from the EX stage.
- mem_fwd  in  forwarding::t  entry from the MEM stage.
- wb_fwd  in  forwarding::t  entry from the WB stage.
- rs1_addr, rs2_addr  in  5 each  decode source addresses.
- rs1_used, rs2_used  in  1 each  source actually read.
- rs1_rf, rs2_rf  in  32 each  register-file read data.
- mc_issue  in  1  multicycle op leaves decode.
- mc_rd  in  5  destination of mc_issue.
- mc_done  in  1  multicycle op completes.
- mc_done_rd  in  5  destination of mc_done.
- stats_clr  in  1  clear stall counter.
- rs1_data, rs2_data  out  32 each  resolved operands.
- stall  out  1  hold decode this cycle.
- pending  out  32  scoreboard bits.
- state  out  2  registered stall-cause FSM state.
- stall_cycles  out  32  stall counter; present only with the macro.

Function
REQ-003 SHALL resolve each operand combinationally; priority EX > MEM > WB > rsX_rf.
REQ-004 SHALL count an entry as a match only if address == rsX_addr and address != 0.
REQ-005 SHALL drive rsX_data = 0 when rsX_addr == 0, regardless of entries.
REQ-006 SHALL raise a load hazard when the highest-priority match has data_valid = 0 and rsX_used = 1; lower-priority matches are ignored.
REQ-007 SHALL raise an MC hazard when rsX_used = 1 and pending[rsX_addr] = 1, unless mc_done = 1 with mc_done_rd == rsX_addr in the same cycle.
REQ-008 SHALL drive stall = load hazard OR MC hazard, combinationally with zero-cycle latency.
REQ-009 SHALL set pending[mc_rd] on the next edge when mc_issue = 1, stall = 0 and mc_rd != 0; mc_issue is ignored while stall = 1.
REQ-010 SHALL clear pending[mc_done_rd] on the next edge when mc_done = 1.
REQ-011 SHALL let set win when set and clear target the same register in one cycle.
REQ-012 SHALL keep pending[0] = 0 at all times.
REQ-013 SHALL implement FSM RUN(0), LOAD_STALL(1), MC_STALL(2), updated every edge:
- load hazard -> LOAD_STALL;
- else MC hazard -> MC_STALL;
- else RUN.
- Load hazard has precedence when both hazards are present.
REQ-014 SHALL register state only; state reflects the previous cycle's cause.

Reset
REQ-015 SHALL, on rst_n = 0, asynchronously force pending = 0, state = RUN and stall_cycles = 0.
REQ-016 SHALL lose in-flight scoreboard entries on reset mid-operation; mc_done after reset for a non-pending register SHALL be harmless.

Configuration
REQ-017 SHALL, with FORWARDING_CTRL_STATS_EN defined, provide stall_cycles:
- increments on each edge with stall = 1;
- saturates at 32'hFFFF_FFFF;
- stats_clr = 1 zeroes it and has priority over increment.
REQ-018 SHALL, without FORWARDING_CTRL_STATS_EN, omit the stall_cycles port and counter logic; stats_clr is then unused.

Structure
REQ-019 SHALL use the shared forwarding package type forwarding::t for stage entries.
REQ-020 SHALL add to the forwarding package:
- the FSM state enum ctrl_state_t;
- the constant NUM_FWD_SRC = 3.
REQ-021 SHALL place per-operand priority selection and hazard detection in sub-module forwarding_mux, instantiated twice (rs1, rs2).

Verification
REQ-022 SHALL cover:
- EX {valid=1, data=0xAAAA0001, addr=5}, MEM {1, 0xBBBB0002, 5}, rs1_addr=5 -> rs1_data = 0xAAAA0001, stall = 0.
- EX {valid=0, addr=7}, MEM {1, 0x12, 7}, rs2_addr=7, rs2_used=1 -> stall = 1; next cycle state = LOAD_STALL. Same with rs2_used=0 -> stall = 0.
- rs1_addr=0, WB {1, 0xFFFFFFFF, 0} -> rs1_data = 0, stall = 0.
- Scoreboard sequence:
  - mc_issue with mc_rd=9 -> pending = 0x200.
  - rs1_addr=9 -> stall = 1, state = MC_STALL.
  - mc_done with rd=9 same cycle -> stall = 0, pending = 0 next cycle.
- mc_issue rd=3 with mc_done rd=3 same cycle -> pending[3] = 1. Assert rst_n low mid-stall -> pending = 0 and state = RUN immediately.
- With FORWARDING_CTRL_STATS_EN:
  - 4 stall cycles -> stall_cycles = 4;
  - stats_clr together with stall -> 0;
  - preload near max -> holds at 0xFFFFFFFF.
